// File: rtl/snn_pkg.sv
// Shared SNN types: source tags and arbiter FSM states.
// Imported by psum_arbiter and its helpers.
package snn_pkg;

  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_PE1 = 2'd1;
  localparam logic [1:0] SRC_PE2 = 2'd2;
  localparam logic [1:0] SRC_PE3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// 4-way round-robin picker: first set req bit after ptr_i.
// Ports: req_i (masked requests), ptr_i (last grant), gnt_o/idx_o/any_o.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = ptr_i;
    any_o = 1'b0;
    cand  = '0;
    // k=4 wraps back to ptr_i itself, lowest priority
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_i + 2'(k);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_arbiter.sv
// Partial-sum arbiter: merges memory + 3 PE sources into a tagged stream.
// Ports: clk/reset, start, src_valid/src_data/src_ready, out_*, busy, done.
module psum_arbiter
  import snn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FT     = 9,
  parameter int NROUND = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            src_valid,
  input  logic [3:0][WIDTH-1:0] src_data,
  output logic [3:0]            src_ready,
  output logic                  out_valid,
  output logic [WIDTH+1:0]      out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = $clog2(NROUND + 1);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH+1:0] out_data_q, out_data_d;
  logic [3:0]       served_q, served_d;
  logic [RW-1:0]    round_q, round_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             done_q, done_d;

  logic             slot_free;
  logic             pre_ft;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gidx;
  logic             gany;
  logic             inject;
  logic [3:0]       served_upd;
  logic [WIDTH-1:0] psum;

  assign slot_free = !out_valid_q || out_ready;
  assign pre_ft    = round_q < RW'(FT);

  // Before FT, memory has nothing to offer: it always
  // "requests" so that its slot gets a zero injected.
  always_comb begin
    req = src_valid & ~served_q;
    if (pre_ft) req[0] = ~served_q[0];
  end

  rr_arbiter4 u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign inject     = gnt[0] && pre_ft;
  assign served_upd = served_q | gnt;
  assign psum       = inject ? '0 : src_data[gidx];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    served_d    = served_q;
    round_d     = round_q;
    ptr_d       = ptr_q;
    done_d      = 1'b0;
    src_ready   = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARB;
          served_d = '0;
          round_d  = '0;
          ptr_d    = 2'd3;
        end
      end
      ARB: begin
        if (slot_free && gany) begin
          src_ready   = inject ? 4'b0000 : gnt;
          out_valid_d = 1'b1;
          out_data_d  = {gidx, psum};
          ptr_d       = gidx;
          if (&served_upd) begin
            served_d = '0;
            round_d  = round_q + RW'(1);
            if (round_q == RW'(NROUND - 1))
              state_d = FLUSH;
          end else begin
            served_d = served_upd;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      served_q    <= '0;
      round_q     <= '0;
      ptr_q       <= 2'd3;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      served_q    <= served_d;
      round_q     <= round_d;
      ptr_q       <= ptr_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: doc/psum_arbiter.md
PSUM_ARBITER -- requirements
Module: psum_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, partial-sum data width.
REQ-002 SHALL have parameter FT, default 9, number of leading rounds with no membrane-potential input from memory.
REQ-003 SHALL have parameter NROUND, default 25, rounds (output neurons) per layer pass.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a layer pass.
REQ-007 SHALL have ports src_valid[3:0]  in  4  request per source; 0=memory, 1=PE1, 2=PE2, 3=PE3.
REQ-008 SHALL have ports src_data[3:0]  in  4 x WIDTH  partial sum per source.
REQ-009 SHALL have ports src_ready[3:0]  out  4  per-source accept, one-hot or zero.
REQ-010 SHALL have port out_valid  out  1  tagged word available to the sum unit.
REQ-011 SHALL have port out_data  out  WIDTH+2  {tag[1:0], psum[WIDTH-1:0]}, tag equals source index.
REQ-012 SHALL have port out_ready  in  1  sum unit accepts out_data.
REQ-013 SHALL have port busy  out  1  pass in progress.
REQ-014 SHALL have port done  out  1  one-cycle pulse when the pass completes.

Function
REQ-015 SHALL implement states IDLE, ARB and FLUSH; IDLE->ARB on start, ARB->FLUSH when the last grant of round NROUND-1 is made, FLUSH->IDLE when the output register drains.
REQ-016 SHALL hold a one-entry output register; a slot is free when out_valid=0 or out_valid&&out_ready in the same cycle.
REQ-017 SHALL, in ARB with a free slot, grant exactly one eligible source per cycle, assert its src_ready combinationally in that cycle, and present the word on out_data at the next edge (latency 1, throughput 1 word/cycle).
REQ-018 SHALL treat a source as eligible only when src_valid=1 and it is not yet marked as served in the current round's 4-bit served mask.
REQ-019 SHALL use round-robin priority starting after the last granted index; after reset or start the pointer is 3, so index 0 has first priority.
REQ-020 SHALL, while round_cnt < FT, never assert src_ready[0]; instead, when the round-robin pointer selects index 0, it SHALL auto-inject tag 00 with data 0 and mark index 0 as served.
REQ-021 SHALL, when the served mask becomes 4'b1111, clear the mask and increment round_cnt in the same edge.
REQ-022 SHALL stall grants, with src_ready all 0, while the slot is not free; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 SHALL ignore start when busy=1.
REQ-024 SHALL assert busy in ARB and FLUSH, and pulse done for one cycle on the FLUSH->IDLE transition.
REQ-025 SHALL keep round_cnt at width $clog2(NROUND+1) and never wrap within a pass.

Reset
REQ-026 SHALL, on reset asserted at any time, including mid-round, force the state to IDLE, out_valid=0, out_data=0, src_ready=0, busy=0, done=0, served=0, round_cnt=0 and pointer=3.
REQ-027 SHALL discard a word held in the output register at reset; it is not delivered after reset.

Structure
REQ-028 SHALL place the source-tag constants (SRC_MEM=0, SRC_PE1=1, SRC_PE2=2, SRC_PE3=3) and the state enum in a shared package snn_pkg.
REQ-029 SHALL contain one sub-module rr_arbiter4, a 4-way round-robin priority picker with a mask input.

Verification
REQ-030 SHALL verify this scenario: start, all four sources valid with data 10/20/30/40, out_ready=1, round 0 -> words 0x000 (injected), 0x114, 0x21E, 0x328 on successive cycles, with src_ready[0] never high.
REQ-031 SHALL verify this scenario: round 9 (FT reached), memory data 5 -> a tag-00 word with value 5 is emitted and src_ready[0] pulses once.
REQ-032 SHALL verify this scenario: PE1 holds valid across two rounds -> exactly one grant to PE1 per round, with no grant while its served bit is set.
REQ-033 SHALL verify this scenario: out_ready=0 for 5 cycles mid-round -> out_data stable, src_ready all 0, and the stream resumes without loss or duplication.
REQ-034 SHALL verify this scenario: NROUND=25 full pass -> 100 output words, done pulses once, busy falls on the same edge, and a start during the pass is ignored.
REQ-035 SHALL verify this scenario: reset asserted with out_valid=1 in round 3 -> all outputs 0 asynchronously, and the next start begins again at round 0 with injected memory zeros.
